// File: rtl/sma_level_detect.sv
// sma_level_detect: divide-by-4 average of a moving sum, debounced hysteresis level,
// rise/fall events with crossing value or high-period peak on a valid/ready port.
module sma_level_detect #(
   parameter int WIDTH = 16,
   parameter int HI_TH = 1000,
   parameter int LO_TH = 500,
   parameter int HOLD  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] sum,
   output logic signed [WIDTH-1:0] avg,
   output logic                    level,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic                    evt_rise,
   output logic signed [WIDTH-1:0] evt_data,
   output logic                    overrun
);
   localparam logic signed [WIDTH-1:0] HI = WIDTH'(HI_TH);
   localparam logic signed [WIDTH-1:0] LO = WIDTH'(LO_TH);
   localparam logic [3:0] HOLD_C = 4'(HOLD);
   typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic signed [WIDTH-1:0] avg_q, avg_d, peak_q, peak_d, peak_max, ev_data, evt_data_q, evt_data_d;
   logic level_q, level_d, evt_valid_q, evt_valid_d, evt_rise_q, evt_rise_d, overrun_q, overrun_d;
   logic q_hi, q_lo, cnt_done, rise_hit, fall_hit, ev_new, load;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q     <= LOW;
         cnt_q       <= '0;
         avg_q       <= '0;
         peak_q      <= '0;
         level_q     <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_rise_q  <= 1'b0;
         evt_data_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         avg_q       <= avg_d;
         peak_q      <= peak_d;
         level_q     <= level_d;
         evt_valid_q <= evt_valid_d;
         evt_rise_q  <= evt_rise_d;
         evt_data_q  <= evt_data_d;
         overrun_q   <= overrun_d;
      end
   always_comb begin
      avg_d    = sum >>> 2;
      q_hi     = avg_q > HI;
      q_lo     = avg_q < LO;
      peak_max = (avg_q > peak_q) ? avg_q : peak_q;
      cnt_done = cnt_q + 4'd1 == HOLD_C;
      // a completed count, or the first qualifying sample when HOLD is 1
      rise_hit = q_hi && ((state_q == LOW && HOLD_C == 4'd1) || (state_q == RISE_PEND && cnt_done));
      fall_hit = q_lo && ((state_q == HIGH && HOLD_C == 4'd1) || (state_q == FALL_PEND && cnt_done));
      state_d  = state_q;
      cnt_d    = cnt_q;
      peak_d   = peak_q;
      level_d  = level_q;
      case (state_q)
         LOW: if (q_hi) begin
            state_d = RISE_PEND;
            cnt_d   = 4'd1;
         end
         RISE_PEND: if (!q_hi) begin
            state_d = LOW;
            cnt_d   = '0;
         end else cnt_d = cnt_q + 4'd1;
         HIGH: begin
            peak_d = peak_max;
            if (q_lo) begin
               state_d = FALL_PEND;
               cnt_d   = 4'd1;
            end
         end
         FALL_PEND: begin
            peak_d = peak_max;
            if (!q_lo) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 4'd1;
         end
      endcase
      if (rise_hit) begin
         state_d = HIGH;
         level_d = 1'b1;
         peak_d  = avg_q;
         cnt_d   = '0;
      end
      if (fall_hit) begin
         state_d = LOW;
         level_d = 1'b0;
         cnt_d   = '0;
      end
      ev_new  = rise_hit | fall_hit;
      ev_data = rise_hit ? avg_q : peak_max;
   end
   always_comb begin
      // a new event only displaces the held one if that one is leaving this edge
      load        = ev_new & (~evt_valid_q | evt_ready);
      evt_valid_d = ev_new | (evt_valid_q & ~evt_ready);
      evt_rise_d  = load ? rise_hit : evt_rise_q;
      evt_data_d  = load ? ev_data : evt_data_q;
      overrun_d   = overrun_q | (ev_new & evt_valid_q & ~evt_ready);
      avg         = avg_q;
      level       = level_q;
      evt_valid   = evt_valid_q;
      evt_rise    = evt_rise_q;
      evt_data    = evt_data_q;
      overrun     = overrun_q;
   end
endmodule

// File: tb/tb_sma_level_detect.sv
// tb_sma_level_detect: directed plus random stimulus against a history-based reference model.
module tb_sma_level_detect;
   localparam int HOLD = 4;
   localparam int HI = 1000;
   localparam int LO = 500;
   logic clk = 1'b0, rst = 1'b0, evt_ready = 1'b1;
   logic signed [15:0] sum = '0;
   logic signed [15:0] avg, evt_data;
   logic level, evt_valid, evt_rise, overrun;
   int passed = 0, fails = 0, total = 0;
   logic signed [15:0] m_avg, m_peak, e_data;
   logic m_level, e_valid, e_rise, e_ovr;
   int hist[$];

   sma_level_detect #(.WIDTH(16), .HI_TH(HI), .LO_TH(LO), .HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .sum(sum), .avg(avg), .level(level),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_rise(evt_rise),
      .evt_data(evt_data), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_avg = '0; m_peak = '0; e_data = '0;
      m_level = 1'b0; e_valid = 1'b0; e_rise = 1'b0; e_ovr = 1'b0;
      hist.delete();
   endtask

   // level flips when the last HOLD averages seen all sit beyond the relevant threshold
   function automatic bit all_last(input bit hi);
      if (hist.size() < HOLD) return 1'b0;
      for (int i = hist.size() - HOLD; i < hist.size(); i++)
         if (hi ? !(hist[i] > HI) : !(hist[i] < LO)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge();
      bit ev = 1'b0, ev_r = 1'b0;
      logic signed [15:0] ev_d = '0;
      hist.push_back(int'(m_avg));
      if (hist.size() > HOLD) void'(hist.pop_front());
      if (!m_level) begin
         if (all_last(1'b1)) begin
            m_level = 1'b1; m_peak = m_avg; ev = 1'b1; ev_r = 1'b1; ev_d = m_avg;
         end
      end else begin
         if (m_avg > m_peak) m_peak = m_avg;
         if (all_last(1'b0)) begin
            m_level = 1'b0; ev = 1'b1; ev_d = m_peak;
         end
      end
      if (ev && (!e_valid || evt_ready)) begin
         e_valid = 1'b1; e_rise = ev_r; e_data = ev_d;
      end else if (ev) e_ovr = 1'b1;
      else if (e_valid && evt_ready) e_valid = 1'b0;
      m_avg = sum >>> 2;
   endtask

   task automatic tick(input logic signed [15:0] s, input logic r);
      sum = s;
      evt_ready = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("avg", avg, m_avg);
      chk("level", level, m_level);
      chk("evt_valid", evt_valid, e_valid);
      chk("overrun", overrun, e_ovr);
      if (e_valid) begin
         chk("evt_rise", evt_rise, e_rise);
         chk("evt_data", evt_data, e_data);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_avg"}, avg, 0);
      chk({tag, "_level"}, level, 0);
      chk({tag, "_valid"}, evt_valid, 0);
      chk({tag, "_rise"}, evt_rise, 0);
      chk({tag, "_data"}, evt_data, 0);
      chk({tag, "_ovr"}, overrun, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      model_reset();
      chk_reset("rst");
      rst = 1'b1;
      repeat (5) tick(16'sd4008, 1'b1);
      chk("rise_level", level, 1);
      chk("rise_valid", evt_valid, 1);
      chk("rise_flag", evt_rise, 1);
      chk("rise_data", evt_data, 1002);
      rst = 1'b0;
      #2;
      model_reset();
      chk_reset("mid_rst");
      rst = 1'b1;
      repeat (4) tick(16'sd4008, 1'b1);
      chk("no_evt_after_rst", evt_valid, 0);
      tick(16'sd4008, 1'b1);
      chk("requal_level", level, 1);
      repeat (2) tick(16'sd8000, 1'b1);
      repeat (10) tick(16'sd2800, 1'b1);
      chk("hyst_level", level, 1);
      repeat (5) tick(16'sd1996, 1'b1);
      chk("fall_valid", evt_valid, 1);
      chk("fall_flag", evt_rise, 0);
      chk("fall_peak", evt_data, 2000);
      repeat (3) tick(16'sd4008, 1'b1);
      repeat (3) tick(16'sd0, 1'b1);
      chk("glitch_level", level, 0);
      repeat (3) tick(16'sd4008, 1'b1);
      tick(16'sd0, 1'b1);
      repeat (4) tick(16'sd4008, 1'b1);
      chk("glitch2_pending", level, 0);
      tick(16'sd4008, 1'b1);
      chk("glitch2_level", level, 1);
      repeat (5) tick(16'sd1996, 1'b1);
      tick(16'sd1996, 1'b1);
      repeat (5) tick(16'sd4008, 1'b0);
      repeat (5) tick(16'sd1996, 1'b0);
      chk("bp_ovr", overrun, 1);
      chk("bp_held_flag", evt_rise, 1);
      chk("bp_held_data", evt_data, 1002);
      tick(16'sd1996, 1'b1);
      chk("bp_drain", evt_valid, 0);
      chk("bp_ovr_sticky", overrun, 1);
      tick(-16'sd5, 1'b1);
      chk("avg_m5", avg, -2);
      tick(-16'sd32768, 1'b1);
      chk("avg_min", avg, -8192);
      tick(16'sd32767, 1'b1);
      chk("avg_max", avg, 8191);
      rst = 1'b0;
      #2;
      model_reset();
      chk_reset("rand_rst");
      rst = 1'b1;
      for (int seg = 0; seg < 400; seg++) begin
         int len = int'($urandom_range(1, 8));
         int kind = int'($urandom_range(0, 3));
         for (int k = 0; k < len; k++) begin
            int v;
            case (kind)
               0: v = 4004 + int'($urandom_range(0, 28763));
               1: v = int'($urandom_range(0, 34767)) - 32768;
               2: v = 2000 + int'($urandom_range(0, 2003));
               default: v = int'($urandom_range(0, 65535));
            endcase
            tick(16'(v), $urandom_range(0, 3) != 0);
         end
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
